// File: rtl/modn_updown_counter.sv
// Modulo-MOD up/down counter with synchronous clear/load, cascade enable and
// wrap-or-saturate boundary handling. Event pulses are registered; tc is combinational.
module modn_updown_counter #(
    parameter int WIDTH     = 3,
    parameter int MOD       = 5,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             en,
    input  logic             cnt_in_en,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             wrap,
    output logic             sat_hit,
    output logic             load_err
);

    // One extra bit lets MOD == 2**WIDTH be represented and compared.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] MAX_Q = MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_Q = (WIDTH)'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_Q = (WIDTH)'(1);

    if (WIDTH < 1 || MOD < 2 || (64'(MOD) > (64'd1 << WIDTH)) ||
        RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_params
        $error("modn_updown_counter: illegal WIDTH/MOD/RESET_VAL combination");
    end

    logic [WIDTH:0]   q_ext_s;
    logic [WIDTH:0]   d_ext_s;
    logic             at_top_s;
    logic             at_bot_s;
    logic             boundary_s;
    logic             d_oob_s;
    logic             step_s;

    logic [WIDTH-1:0] q_d,    q_q;
    logic             wrap_d, wrap_q;
    logic             sat_d,  sat_q;
    logic             lerr_d, lerr_q;

    assign q_ext_s    = {1'b0, q_q};
    assign d_ext_s    = {1'b0, d_in};
    assign at_top_s   = (q_ext_s == MAX_W);
    assign at_bot_s   = (q_q == {WIDTH{1'b0}});
    assign boundary_s = up_dn ? at_top_s : at_bot_s;
    assign d_oob_s    = (d_ext_s >= MOD_W);
    assign step_s     = en & cnt_in_en & ~clr & ~load;

    // tc announces that this cycle's edge will wrap, so the next stage can step with it.
    assign tc = step_s & ~sat_mode & boundary_s;

    // Next count and event pulses: clr > load > step > hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        lerr_d = 1'b0;
        if (clr) begin
            q_d = RST_Q;
        end else if (load) begin
            if (d_oob_s) begin
                q_d    = MAX_Q;
                lerr_d = 1'b1;
            end else begin
                q_d = d_in;
            end
        end else if (step_s) begin
            if (!boundary_s) begin
                q_d = up_dn ? (q_q + ONE_Q) : (q_q - ONE_Q);
            end else if (sat_mode) begin
                sat_d = 1'b1;
            end else begin
                q_d    = up_dn ? {WIDTH{1'b0}} : MAX_Q;
                wrap_d = 1'b1;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Count and pulse registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= RST_Q;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
            lerr_q <= lerr_d;
        end
    end

    assign q_out    = q_q;
    assign wrap     = wrap_q;
    assign sat_hit  = sat_q;
    assign load_err = lerr_q;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Scoreboard bench: a mod-5 counter, a mod-4 (full-range) counter and a two-stage
// decade cascade are driven together and checked against arithmetic reference models.
module tb_modn_updown_counter;

    typedef struct {
        bit clr; bit load; int d; bit en; bit cin; bit up; bit sat;
        bit c_clr; bit c_en; bit c_cin; bit c_up;
    } stim_t;

    typedef struct { int q; bit wrap; bit sat; bit lerr; } st_t;

    typedef struct {
        int edge_n;
        st_t m; st_t f;
        int c_val; bit lo_wrap; bit hi_wrap;
    } exp_st_t;

    typedef struct { int edge_n; bit tc_m; bit tc_f; bit tc_lo; bit tc_hi; } exp_tc_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clr, load, en, cnt_in_en, up_dn, sat_mode;
    logic [2:0] d_in;
    logic [1:0] d_in_f;
    logic       c_clr, c_en, c_cin, c_up;
    logic       c_load = 1'b0;
    logic       c_sat  = 1'b0;
    logic [3:0] c_d    = 4'd0;

    logic [2:0] m_q;
    logic       m_tc, m_wrap, m_sat, m_lerr;
    logic [1:0] f_q;
    logic       f_tc, f_wrap, f_sat, f_lerr;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_wrap, lo_sat, lo_lerr;
    logic       hi_tc, hi_wrap, hi_sat, hi_lerr;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int mdl_m = 0;
    int mdl_f = 2;
    int mdl_c = 0;

    exp_st_t stq[$];
    exp_tc_t tcq[$];

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    modn_updown_counter #(.WIDTH(3), .MOD(5), .RESET_VAL(0)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .d_in(d_in),
        .en(en), .cnt_in_en(cnt_in_en), .up_dn(up_dn), .sat_mode(sat_mode),
        .q_out(m_q), .tc(m_tc), .wrap(m_wrap), .sat_hit(m_sat), .load_err(m_lerr));

    modn_updown_counter #(.WIDTH(2), .MOD(4), .RESET_VAL(2)) dut_full (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .d_in(d_in_f),
        .en(en), .cnt_in_en(cnt_in_en), .up_dn(up_dn), .sat_mode(sat_mode),
        .q_out(f_q), .tc(f_tc), .wrap(f_wrap), .sat_hit(f_sat), .load_err(f_lerr));

    modn_updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) dut_lo (
        .clk(clk), .reset_n(reset_n), .clr(c_clr), .load(c_load), .d_in(c_d),
        .en(c_en), .cnt_in_en(c_cin), .up_dn(c_up), .sat_mode(c_sat),
        .q_out(lo_q), .tc(lo_tc), .wrap(lo_wrap), .sat_hit(lo_sat), .load_err(lo_lerr));

    modn_updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) dut_hi (
        .clk(clk), .reset_n(reset_n), .clr(c_clr), .load(c_load), .d_in(c_d),
        .en(c_en), .cnt_in_en(lo_tc), .up_dn(c_up), .sat_mode(c_sat),
        .q_out(hi_q), .tc(hi_tc), .wrap(hi_wrap), .sat_hit(hi_sat), .load_err(hi_lerr));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: behaviour of one edge for a modulo-m counter.
    function automatic st_t ref_next(input int q, input int m, input int rv,
                                     input bit clr_v, input bit load_v, input int d,
                                     input bit step_v, input bit up_v, input bit sat_v);
        st_t r;
        r.q = q; r.wrap = 1'b0; r.sat = 1'b0; r.lerr = 1'b0;
        if (clr_v) r.q = rv;
        else if (load_v) begin
            if (d < m) r.q = d;
            else begin r.q = m - 1; r.lerr = 1'b1; end
        end else if (step_v) begin
            if (up_v) begin
                if (q == m - 1 && sat_v) r.sat = 1'b1;
                else begin r.q = (q + 1) % m; r.wrap = (q == m - 1); end
            end else begin
                if (q == 0 && sat_v) r.sat = 1'b1;
                else begin r.q = (q + m - 1) % m; r.wrap = (q == 0); end
            end
        end
        return r;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.clr = 1'b0; s.load = 1'b0; s.d = 0; s.en = 1'b0; s.cin = 1'b1;
        s.up = 1'b1; s.sat = 1'b0;
        s.c_clr = 1'b0; s.c_en = 1'b0; s.c_cin = 1'b1; s.c_up = 1'b1;
        return s;
    endfunction

    task automatic set_inputs(input stim_t s);
        clr = s.clr; load = s.load; d_in = s.d[2:0]; d_in_f = s.d[1:0];
        en = s.en; cnt_in_en = s.cin; up_dn = s.up; sat_mode = s.sat;
        c_clr = s.c_clr; c_en = s.c_en; c_cin = s.c_cin; c_up = s.c_up;
    endtask

    // Apply one cycle of stimulus and queue what the next edge must produce.
    task automatic apply(input stim_t s);
        exp_st_t e;
        exp_tc_t t;
        bit c_step;
        @(posedge clk);
        #1;
        set_inputs(s);
        e.edge_n = edge_cnt + 1;
        t.edge_n = edge_cnt + 1;
        e.m = ref_next(mdl_m, 5, 0, s.clr, s.load, s.d % 8, s.en && s.cin, s.up, s.sat);
        e.f = ref_next(mdl_f, 4, 2, s.clr, s.load, s.d % 4, s.en && s.cin, s.up, s.sat);
        t.tc_m = e.m.wrap;
        t.tc_f = e.f.wrap;
        c_step = s.c_en && s.c_cin && !s.c_clr;
        t.tc_lo = c_step && (s.c_up ? (mdl_c % 10 == 9) : (mdl_c % 10 == 0));
        t.tc_hi = c_step && (s.c_up ? (mdl_c == 99) : (mdl_c == 0));
        if (s.c_clr) mdl_c = 0;
        else if (c_step) mdl_c = s.c_up ? (mdl_c + 1) % 100 : (mdl_c + 99) % 100;
        mdl_m = e.m.q;
        mdl_f = e.f.q;
        e.c_val = mdl_c;
        e.lo_wrap = t.tc_lo;
        e.hi_wrap = t.tc_hi;
        stq.push_back(e);
        tcq.push_back(t);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_m_q"}, 32'(m_q), 32'd0);
        chk({tag, "_m_pulses"}, 32'({m_wrap, m_sat, m_lerr}), 32'd0);
        chk({tag, "_f_q"}, 32'(f_q), 32'd2);
        chk({tag, "_f_pulses"}, 32'({f_wrap, f_sat, f_lerr}), 32'd0);
        chk({tag, "_casc"}, 32'({hi_q, lo_q}), 32'd0);
    endtask

    // Let the pending edge land, then pull reset low mid-cycle and check it bites at once.
    task automatic do_mid_reset();
        exp_st_t e;
        @(posedge clk);
        @(negedge clk);
        #1;
        set_inputs(idle_stim());
        reset_n = 1'b0;
        mdl_m = 0; mdl_f = 2; mdl_c = 0;
        #1;
        chk_reset_state("async_rst");
        e.m = '{q: 0, wrap: 1'b0, sat: 1'b0, lerr: 1'b0};
        e.f = '{q: 2, wrap: 1'b0, sat: 1'b0, lerr: 1'b0};
        e.c_val = 0; e.lo_wrap = 1'b0; e.hi_wrap = 1'b0;
        e.edge_n = edge_cnt + 1;
        stq.push_back(e);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        e.edge_n = edge_cnt + 1;
        stq.push_back(e);
    endtask

    // Monitor: compares registered results for past edges and tc for the coming edge.
    always @(negedge clk) begin : monitor
        exp_st_t e;
        exp_tc_t t;
        while (stq.size() > 0 && stq[0].edge_n <= edge_cnt) begin
            e = stq.pop_front();
            chk("m_q", 32'(m_q), 32'(e.m.q));
            chk("m_wrap", 32'(m_wrap), 32'(e.m.wrap));
            chk("m_sat_hit", 32'(m_sat), 32'(e.m.sat));
            chk("m_load_err", 32'(m_lerr), 32'(e.m.lerr));
            chk("f_q", 32'(f_q), 32'(e.f.q));
            chk("f_wrap", 32'(f_wrap), 32'(e.f.wrap));
            chk("f_sat_hit", 32'(f_sat), 32'(e.f.sat));
            chk("c_hi", 32'(hi_q), 32'(e.c_val / 10));
            chk("c_lo", 32'(lo_q), 32'(e.c_val % 10));
            chk("c_lo_wrap", 32'(lo_wrap), 32'(e.lo_wrap));
            chk("c_hi_wrap", 32'(hi_wrap), 32'(e.hi_wrap));
            chk("c_sat_lerr", 32'({lo_sat, hi_sat, lo_lerr, hi_lerr}), 32'd0);
        end
        while (tcq.size() > 0 && tcq[0].edge_n <= edge_cnt) void'(tcq.pop_front());
        if (tcq.size() > 0 && tcq[0].edge_n == edge_cnt + 1) begin
            t = tcq.pop_front();
            chk("m_tc", 32'(m_tc), 32'(t.tc_m));
            chk("f_tc", 32'(f_tc), 32'(t.tc_f));
            chk("c_lo_tc", 32'(lo_tc), 32'(t.tc_lo));
            chk("c_hi_tc", 32'(hi_tc), 32'(t.tc_hi));
        end
    end

    initial begin
        stim_t s;
        set_inputs(idle_stim());
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_state("por");
        reset_n = 1'b1;

        // Count up with wrap, then down from 0 with wrap.
        s = idle_stim(); s.en = 1'b1; s.up = 1'b1;
        repeat (7) apply(s);
        s = idle_stim(); s.clr = 1'b1; s.en = 1'b1;
        apply(s);
        s = idle_stim(); s.en = 1'b1; s.up = 1'b0;
        repeat (6) apply(s);

        // Saturation at both ends.
        s = idle_stim(); s.load = 1'b1; s.d = 3; s.en = 1'b1;
        apply(s);
        s = idle_stim(); s.en = 1'b1; s.up = 1'b1; s.sat = 1'b1;
        repeat (3) apply(s);
        s = idle_stim(); s.clr = 1'b1;
        apply(s);
        s = idle_stim(); s.en = 1'b1; s.up = 1'b0; s.sat = 1'b1;
        repeat (2) apply(s);

        // Out-of-range load clamps; clr beats load.
        s = idle_stim(); s.load = 1'b1; s.d = 6; s.en = 1'b1;
        apply(s);
        s = idle_stim(); s.load = 1'b1; s.d = 2; s.clr = 1'b1; s.en = 1'b1;
        apply(s);

        // Decade cascade: 25 counts, then cascade enable low.
        s = idle_stim(); s.c_clr = 1'b1;
        apply(s);
        s = idle_stim(); s.c_en = 1'b1; s.c_cin = 1'b1; s.c_up = 1'b1;
        repeat (25) apply(s);
        s.c_cin = 1'b0;
        repeat (3) apply(s);

        // Asynchronous reset while sitting at 3, then one up step.
        s = idle_stim(); s.load = 1'b1; s.d = 3;
        apply(s);
        do_mid_reset();
        s = idle_stim(); s.en = 1'b1; s.up = 1'b1;
        apply(s);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_mid_reset();
            s.clr   = ($urandom_range(19, 0) == 0);
            s.load  = ($urandom_range(7, 0) == 0);
            s.d     = int'($urandom_range(7, 0));
            s.en    = ($urandom_range(3, 0) != 0);
            s.cin   = ($urandom_range(7, 0) != 0);
            s.up    = ($urandom_range(1, 0) == 1);
            s.sat   = ($urandom_range(3, 0) == 0);
            s.c_clr = ($urandom_range(49, 0) == 0);
            s.c_en  = ($urandom_range(3, 0) != 0);
            s.c_cin = ($urandom_range(7, 0) != 0);
            s.c_up  = ($urandom_range(3, 0) != 0);
            apply(s);
        end

        s = idle_stim();
        apply(s);
        for (int k = 0; k < 5 && stq.size() > 0; k++) @(negedge clk);
        #1;
        if (stq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected results never checked, required 0", stq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
